// File: rtl/rcosc_ctrl_if.sv
// Signal bundle between the RC oscillator controller and its surroundings.
// master drives the request and raw oscillator clock; slave is the controller.
interface rcosc_ctrl_if #(
  parameter int CNT_W = 16
) ();
  logic             osc_req;
  logic             osc_clk;
  logic             osc_en;
  logic             osc_ready;
  logic             osc_fail;
  logic [1:0]       osc_state;
  logic [CNT_W-1:0] osc_period;

  modport master (
    output osc_req,
    output osc_clk,
    input  osc_en,
    input  osc_ready,
    input  osc_fail,
    input  osc_state,
    input  osc_period
  );

  modport slave (
    input  osc_req,
    input  osc_clk,
    output osc_en,
    output osc_ready,
    output osc_fail,
    output osc_state,
    output osc_period
  );
endinterface

// File: rtl/rcosc_ctrl.sv
// Enable/startup sequencer and loss-of-clock monitor for the on-chip RC oscillator;
// also reports the oscillator period in system clock cycles.
module rcosc_ctrl #(
  parameter int SYNC_STAGES    = 2,
  parameter int STARTUP_EDGES  = 8,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int CNT_W          = 16
) (
  input  logic         clk,
  input  logic         resetn,
  rcosc_ctrl_if.slave  osc
);

  localparam int               E_W       = (STARTUP_EDGES > 1) ? $clog2(STARTUP_EDGES) : 1;
  localparam logic [E_W-1:0]   E_LAST    = E_W'(STARTUP_EDGES - 1);
  localparam logic [CNT_W-1:0] G_TIMEOUT = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] G_MAX     = '1;

  typedef enum logic [1:0] {
    ST_OFF   = 2'b00,
    ST_START = 2'b01,
    ST_RUN   = 2'b10,
    ST_FAIL  = 2'b11
  } state_e;

  state_e           state_q, state_d;
  logic [E_W-1:0]   e_q, e_d;
  logic [CNT_W-1:0] g_q, g_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             en_q, ready_q, fail_q;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   delay_q;
  logic                   osc_edge;

  // Synchronizer runs in every state so a restart sees clean history.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      sync_q  <= '0;
      delay_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], osc.osc_clk};
      delay_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign osc_edge = sync_q[SYNC_STAGES-1] & ~delay_q;

  always_comb begin
    state_d  = state_q;
    e_d      = e_q;
    period_d = period_q;
    g_d      = '0;

    unique case (state_q)
      ST_OFF: begin
        if (osc.osc_req) state_d = ST_START;
      end
      ST_START: begin
        if (!osc.osc_req) begin
          state_d = ST_OFF;
        end else if (osc_edge) begin
          if (e_q == E_LAST) state_d = ST_RUN;
          else               e_d     = e_q + E_W'(1);
        end else if (g_q == G_TIMEOUT) begin
          state_d = ST_FAIL;
        end
      end
      ST_RUN: begin
        if (!osc.osc_req) begin
          state_d = ST_OFF;
        end else if (osc_edge) begin
          period_d = (g_q == G_MAX) ? G_MAX : g_q + CNT_W'(1);
        end else if (g_q == G_TIMEOUT) begin
          state_d = ST_FAIL;
        end
      end
      ST_FAIL: begin
        if (!osc.osc_req) state_d = ST_OFF;
      end
      default: state_d = ST_OFF;
    endcase

    // Edge count only survives while sitting in START.
    if (state_d != ST_START) e_d = '0;

    // Gap counter runs only while staying in START/RUN; entry from OFF and
    // every detected edge restart it from zero.
    if ((state_q == ST_START || state_q == ST_RUN) &&
        (state_d == ST_START || state_d == ST_RUN) && !osc_edge) begin
      g_d = (g_q == G_MAX) ? G_MAX : g_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= ST_OFF;
      e_q      <= '0;
      g_q      <= '0;
      period_q <= '0;
      en_q     <= 1'b0;
      ready_q  <= 1'b0;
      fail_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      e_q      <= e_d;
      g_q      <= g_d;
      period_q <= period_d;
      en_q     <= (state_d == ST_START) || (state_d == ST_RUN);
      ready_q  <= (state_d == ST_RUN);
      fail_q   <= (state_d == ST_FAIL);
    end
  end

  assign osc.osc_en     = en_q;
  assign osc.osc_ready  = ready_q;
  assign osc.osc_fail   = fail_q;
  assign osc.osc_state  = state_q;
  assign osc.osc_period = period_q;

endmodule

// File: tb/tb_rcosc_ctrl.sv
// Directed bench for rcosc_ctrl: startup, dead oscillator, loss in RUN,
// abort/restart, timeout-cycle edge priority and mid-run reset.
module tb_rcosc_ctrl;

  localparam int CNT_W = 16;

  logic clk;
  logic resetn;
  int   checks = 0;
  int   errors = 0;

  rcosc_ctrl_if #(.CNT_W(CNT_W)) osc_bus ();

  rcosc_ctrl #(
    .SYNC_STAGES    (2),
    .STARTUP_EDGES  (4),
    .TIMEOUT_CYCLES (50),
    .CNT_W          (CNT_W)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .osc    (osc_bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance n rising edges and land 1 ns after the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
    $display("check %-14s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  // One 20-cycle oscillator period: 10 high, 10 low.
  task automatic osc_cycle();
    osc_bus.osc_clk = 1'b1;
    tick(10);
    osc_bus.osc_clk = 1'b0;
    tick(10);
  endtask

  task automatic check_outs(input string tag, input logic [1:0] st, input logic en,
                            input logic rdy, input logic fl);
    check({tag, ".state"}, 32'(osc_bus.osc_state), 32'(st));
    check({tag, ".en"},    32'(osc_bus.osc_en),    32'(en));
    check({tag, ".ready"}, 32'(osc_bus.osc_ready), 32'(rdy));
    check({tag, ".fail"},  32'(osc_bus.osc_fail),  32'(fl));
  endtask

  initial begin
    resetn          = 1'b0;
    osc_bus.osc_req = 1'b0;
    osc_bus.osc_clk = 1'b0;
    tick(3);
    check_outs("reset", 2'b00, 1'b0, 1'b0, 1'b0);
    check("reset.period", 32'(osc_bus.osc_period), 32'd0);
    resetn = 1'b1;
    tick(1);

    // Normal start: four edges at 20-cycle spacing after a 100 ns delay.
    osc_bus.osc_req = 1'b1;
    tick(1);
    check_outs("start", 2'b01, 1'b1, 1'b0, 1'b0);
    tick(9);
    osc_cycle();
    osc_cycle();
    osc_cycle();
    check_outs("start3", 2'b01, 1'b1, 1'b0, 1'b0);
    osc_bus.osc_clk = 1'b1;
    tick(2);
    check("edge4.pre", 32'(osc_bus.osc_ready), 32'd0);
    tick(1);
    check_outs("run", 2'b10, 1'b1, 1'b1, 1'b0);
    check("run.period0", 32'(osc_bus.osc_period), 32'd0);
    tick(7);
    osc_bus.osc_clk = 1'b0;
    tick(10);
    osc_bus.osc_clk = 1'b1;
    tick(2);
    check("period.pre", 32'(osc_bus.osc_period), 32'd0);
    tick(1);
    check("period20", 32'(osc_bus.osc_period), 32'd20);
    tick(7);
    osc_bus.osc_clk = 1'b0;

    // Loss in RUN: last edge registered 7 cycles ago; fail 51 cycles after it.
    tick(43);
    check_outs("loss.pre", 2'b10, 1'b1, 1'b1, 1'b0);
    tick(1);
    check_outs("loss", 2'b11, 1'b0, 1'b0, 1'b1);
    check("loss.period", 32'(osc_bus.osc_period), 32'd20);
    osc_bus.osc_req = 1'b0;
    tick(1);
    check_outs("loss.off", 2'b00, 1'b0, 1'b0, 1'b0);
    check("off.period", 32'(osc_bus.osc_period), 32'd20);

    // Dead oscillator: START entered, fail 51 cycles later, no retry.
    osc_bus.osc_req = 1'b1;
    tick(1);
    check_outs("dead.start", 2'b01, 1'b1, 1'b0, 1'b0);
    tick(50);
    check_outs("dead.pre", 2'b01, 1'b1, 1'b0, 1'b0);
    tick(1);
    check_outs("dead.fail", 2'b11, 1'b0, 1'b0, 1'b1);
    tick(5);
    check_outs("dead.hold", 2'b11, 1'b0, 1'b0, 1'b1);
    osc_bus.osc_req = 1'b0;
    tick(1);
    check_outs("dead.off", 2'b00, 1'b0, 1'b0, 1'b0);

    // Abort after two edges, then restart needing four fresh edges.
    osc_bus.osc_req = 1'b1;
    tick(1);
    osc_cycle();
    osc_cycle();
    check_outs("abort.pre", 2'b01, 1'b1, 1'b0, 1'b0);
    osc_bus.osc_req = 1'b0;
    tick(1);
    check_outs("abort.off", 2'b00, 1'b0, 1'b0, 1'b0);
    osc_bus.osc_req = 1'b1;
    tick(1);
    osc_cycle();
    osc_cycle();
    osc_cycle();
    check_outs("restart3", 2'b01, 1'b1, 1'b0, 1'b0);
    osc_bus.osc_clk = 1'b1;
    tick(3);
    check_outs("restart.run", 2'b10, 1'b1, 1'b1, 1'b0);
    osc_bus.osc_clk = 1'b0;

    // Edge lands in the cycle where the gap counter reads the timeout value.
    tick(48);
    osc_bus.osc_clk = 1'b1;
    tick(2);
    check_outs("tmo.pre", 2'b10, 1'b1, 1'b1, 1'b0);
    tick(1);
    check_outs("tmo.edge", 2'b10, 1'b1, 1'b1, 1'b0);
    check("tmo.period", 32'(osc_bus.osc_period), 32'd51);

    // Reset mid-RUN with request still asserted.
    resetn = 1'b0;
    tick(1);
    check_outs("rst.run", 2'b00, 1'b0, 1'b0, 1'b0);
    check("rst.period", 32'(osc_bus.osc_period), 32'd0);
    resetn = 1'b1;
    tick(1);
    check_outs("rst.start", 2'b01, 1'b1, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
